// File: rtl/csa_product_resolver.sv
// rtl/csa_product_resolver.sv - resolves a carry-save product pair into one binary product
// A chunked ripple adder handles CHUNK bits per cycle. Latency is fixed and does not depend on the data.
module csa_product_resolver #(
  parameter int IN_WIDTH  = 18,
  parameter int OUT_WIDTH = 16,
  parameter int CHUNK     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_WIDTH-1:0]  in_sum0,
  input  logic [IN_WIDTH-1:0]  in_sum1,
  input  logic                 in_tc,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_product,
  output logic                 out_neg,
  output logic                 out_zero
);

  localparam int NCHUNK = (IN_WIDTH + CHUNK - 1) / CHUNK;
  localparam int PW     = NCHUNK * CHUNK;
  localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t           state;
  logic [PW-1:0]    op0;
  logic [PW-1:0]    op1;
  logic [PW-1:0]    result;
  logic             tc;
  logic             carry;
  logic [IW-1:0]    idx;

  logic [PW-1:0]    sh0;
  logic [PW-1:0]    sh1;
  logic [PW-1:0]    mask;
  logic [PW-1:0]    res_next;
  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic [CHUNK-1:0] sum_chunk;
  logic             carry_next;
  logic             last;
  int               shamt;

  // Operands are zero-padded to a whole number of chunks, so the top chunk adds zeros above IN_WIDTH.
  always_comb begin
    shamt = int'(idx) * CHUNK;
    sh0 = op0 >> shamt;
    sh1 = op1 >> shamt;
    a_chunk = sh0[CHUNK-1:0];
    b_chunk = sh1[CHUNK-1:0];
    {carry_next, sum_chunk} = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry};
    mask = PW'({CHUNK{1'b1}}) << shamt;
    res_next = (result & ~mask) | (PW'(sum_chunk) << shamt);
    last = (idx == IW'(NCHUNK - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      out_product <= '0;
      out_neg     <= 1'b0;
      out_zero    <= 1'b0;
      op0         <= '0;
      op1         <= '0;
      result      <= '0;
      tc          <= 1'b0;
      carry       <= 1'b0;
      idx         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op0      <= PW'(in_sum0);
            op1      <= PW'(in_sum1);
            tc       <= in_tc;
            result   <= '0;
            carry    <= 1'b0;
            idx      <= '0;
            in_ready <= 1'b0;
            state    <= ADD;
          end
        end
        ADD: begin
          result <= res_next;
          carry  <= carry_next;
          idx    <= idx + 1'b1;
          // The final carry-out is dropped and the sum wraps modulo 2^IN_WIDTH. The upper bits are redundant sign extension.
          if (last) begin
            out_product <= res_next[OUT_WIDTH-1:0];
            out_neg     <= tc & res_next[OUT_WIDTH-1];
            out_zero    <= (res_next[OUT_WIDTH-1:0] == '0);
            out_valid   <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/csa_product_resolver.md
Name: csa_product_resolver

Overview:
- Consumes the redundant two-vector (carry-save) product emitted by the team's combinational Booth partial-product multiplier.
- Resolves the two vectors into a single binary product with a multi-cycle chunked ripple adder.
- Hands the product downstream to the FNMADD datapath over valid/ready.
- Sits between the multiplier's two carry-save outputs and the mantissa add/normalise stage.

Parameters:
- IN_WIDTH, 18, width of each carry-save input vector (matches multiplier out_width = a_width+b_width+2).
- OUT_WIDTH, 16, width of the resolved product (a_width+b_width); must be <= IN_WIDTH.
- CHUNK, 4, bits added per cycle; 1 <= CHUNK <= IN_WIDTH.
- Derived NCHUNK = ceil(IN_WIDTH/CHUNK), 5 at defaults.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  carry-save pair presented.
- in_ready  out  1  block can accept a pair.
- in_sum0  in  IN_WIDTH  carry-save vector 0.
- in_sum1  in  IN_WIDTH  carry-save vector 1.
- in_tc  in  1  1 = signed (two's-complement) product, 0 = unsigned.
- out_valid  out  1  resolved product available.
- out_ready  in  1  downstream accepts product.
- out_product  out  OUT_WIDTH  (in_sum0 + in_sum1) mod 2^OUT_WIDTH.
- out_neg  out  1  in_tc latched AND out_product[OUT_WIDTH-1].
- out_zero  out  1  out_product == 0.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high. On rst high: state=IDLE, in_ready=1, out_valid=0, out_product=0, out_neg=0, out_zero=0, internal carry/index/operand registers cleared.
- FSM states IDLE, ADD, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: latch in_sum0, in_sum1, in_tc; set carry=0, idx=0; go to ADD.
- ADD:
  - in_ready=0.
  - Each cycle add bits [idx*CHUNK +: CHUNK] of both operands plus carry. Write the CHUNK-bit sum into the result register at the same position; carry-out becomes the next carry; idx increments.
  - The final chunk is partial when IN_WIDTH is not a multiple of CHUNK; bits above IN_WIDTH are treated as 0.
  - After chunk NCHUNK-1, go to DONE. The final carry-out is discarded (modulo 2^IN_WIDTH).
- DONE:
  - out_valid=1.
  - out_product = result[OUT_WIDTH-1:0]; out_neg and out_zero are derived from it and held stable.
  - On an edge with out_ready=1: out_valid drops and the state returns to IDLE.
- No overlap: in_ready=0 in ADD and DONE. Input is accepted only in IDLE, so the next accept occurs at the earliest one cycle after the out handshake.
- Latency: if the pair is accepted at edge E, out_valid is high in the cycle after edge E+NCHUNK (6 cycles at defaults). This is fixed and data-independent.
- Backpressure: while out_ready=0 in DONE, all outputs hold indefinitely.
- The upper IN_WIDTH-OUT_WIDTH result bits are dropped; the multiplier's sign extension guarantees they are redundant.
- in_sum0/in_sum1 may change freely after acceptance without affecting the result.
- in_valid held high in DONE has no effect until the block returns to IDLE.
- rst asserted in ADD or DONE aborts immediately, and the in-flight result is lost. The first accept after reset release is a fresh operation.

Test Plan:
1. Unsigned basic: in_sum0=18'h0000A, in_sum1=18'h00005, tc=0 -> out_product=16'h000F, out_neg=0, out_zero=0; out_valid exactly 6 cycles after accept.
2. Cross-chunk carry: in_sum0=18'h0000F, in_sum1=18'h00001 -> 16'h0010. Also in_sum0=18'h0FFFF, in_sum1=18'h00001 -> 16'h0000, out_zero=1 (carry ripples through every chunk).
3. Signed negative: in_sum0=18'h3FFF0, in_sum1=18'h00001, tc=1 -> out_product=16'hFFF1 (-15), out_neg=1. The same vectors with tc=0 -> out_neg=0.
4. Modulo wrap: in_sum0=18'h3FFFF, in_sum1=18'h00001, tc=1 -> out_product=16'h0000, out_zero=1, out_neg=0.
5. Backpressure and flow:
   - Hold out_ready=0 for 5 cycles in DONE -> outputs stable and in_ready=0 throughout.
   - Raise out_ready -> out_valid drops next cycle and in_ready=1.
   - Back-to-back in_valid -> the second pair is accepted only after return to IDLE.
6. Reset mid-op: assert rst asynchronously during the 3rd ADD cycle -> out_valid=0, out_product=0, in_ready=1 immediately. A new pair 18'h00003 + 18'h00004 then yields 16'h0007 at normal latency.
